ifetch_prefetch: RTL and testbench
==================================

Name: ifetch_prefetch

Overview:
- Instruction fetch front-end that sits directly upstream of the single-cycle MIPS datapath and supplies its `instr` word.
- Holds the fetch PC and issues word requests to instruction memory over a req/gnt + rvalid protocol. Responses return in order.
- Buffers returned words in a small FIFO and presents them to the core with a valid/ready handshake.
- Handles redirects (branch/jump/exception target) by flushing the FIFO and discarding responses already in flight.

Parameters:
- DEPTH, 4: FIFO entries and also the maximum number of outstanding requests (power of 2, at least 2).
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset (0 = reset).
- imem_req  out  1  fetch request.
- imem_addr  out  32  word-aligned fetch address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid. In order, at least 1 cycle after grant.
- imem_rdata  in  32  response instruction word.
- redirect  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  32  redirect target.
- instr_valid  out  1  instr/instr_pc valid.
- instr  out  32  instruction word at the FIFO head.
- instr_pc  out  32  address of instr.
- instr_ready  in  1  core consumes the head entry.

Behaviour:
- Reset values:
  - pc = RESET_PC; FIFO empty; outstanding = 0; drop_cnt = 0; state = BOOT.
  - instr_valid = 0; imem_req = 0; instr = 0; instr_pc = 0.
- State BOOT: one cycle, no request; then RUN.
- State RUN:
  - imem_req = !redirect && (fifo_count + outstanding < DEPTH). This is combinational.
  - imem_addr = pc.
  - req && gnt accepts the request: pc <= pc + 4 (wraps 32'hFFFF_FFFC to 0) and outstanding increments.
  - While req is high and gnt is low, imem_addr is held stable.
  - On rvalid: push {imem_rdata, address} into the FIFO. The address comes from a per-request PC queue. outstanding decrements.
  - On the same cycle as rvalid, a grant may also occur; the net change to outstanding is 0.
  - instr_valid = FIFO non-empty and state == RUN. instr and instr_pc show the FIFO head.
  - A pop (valid && ready) and a push may happen in the same cycle, including when the FIFO is full.
  - The FIFO never overflows, by credit.
- Redirect (any state except BOOT):
  - pc <= {redirect_pc[31:2], 2'b00}.
  - FIFO is flushed and instr_valid = 0 in that cycle.
  - Any rvalid in the redirect cycle is discarded.
  - drop_cnt <= outstanding - rvalid.
  - Next state is DRAIN if drop_cnt_next != 0, otherwise RUN.
  - A grant in the redirect cycle cannot occur, because req is forced low.
- State DRAIN:
  - No requests; instr_valid = 0.
  - Each rvalid is discarded and decrements drop_cnt and outstanding.
  - Go to RUN when the last one is discarded (drop_cnt == 1 && rvalid).
  - A redirect during DRAIN updates pc and keeps the existing drop_cnt.
- rvalid with outstanding == 0 is a protocol violation. It is ignored, and no counter underflows.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous). Stale responses after reset are the memory's responsibility.
- Latency: with a 1-cycle-response memory, the first instruction is valid 3 cycles after reset deassertion. Throughput is 1 instruction/cycle sustained.

Optional Feature:
- Macro: IFETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port fetch_err (1 bit, reset 0).
  - A redirect with redirect_pc[1:0] != 0 sets fetch_err. fetch_err is sticky until reset.
  - The FIFO is flushed, and the block enters state HALT: no requests, instr_valid = 0.
  - Remaining outstanding responses are absorbed in HALT.
  - Only reset leaves HALT.
- Not defined: there is no fetch_err port, and redirect_pc[1:0] is silently cleared.

Test Plan:
- Reset release, memory with 1-cycle response (rdata = addr ^ 32'hA5A5_A5A5), instr_ready = 1 -> instr_pc sequence 0, 4, 8, 12 on consecutive cycles, each instr matching.
- instr_ready = 0 for 10 cycles -> exactly DEPTH = 4 grants, then imem_req = 0. Raising ready -> 4 back-to-back pops, then fetch resumes at pc 16.
- gnt held low 3 cycles -> imem_addr stable, pc unchanged. On the grant, pc advances by exactly 4.
- 3-cycle response latency with 3 outstanding, redirect to 32'h0000_0100 -> the 3 stale responses are discarded (no instr_valid), then the first valid instr_pc = 32'h100.
- Redirect to 32'hFFFF_FFF8 -> instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- With IFETCH_MISALIGN_TRAP_EN, redirect to 32'h0000_0102 -> fetch_err = 1 next cycle, no further imem_req, instr_valid = 0 until RST is pulsed low.

Source files
------------

// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: instruction fetch front-end for the single-cycle MIPS core.
// Fetches words over a req/gnt + in-order rvalid bus, buffers them in a
// DEPTH-entry FIFO and hands them to the core over a valid/ready handshake.
// Redirects flush the FIFO and drain responses that are already in flight.
//
// Handshakes:
//   imem: a request is accepted on a cycle with imem_req && imem_gnt; while
//         imem_req is high and imem_gnt low, imem_addr stays stable. Each
//         accepted request returns exactly one imem_rvalid, in order.
//   core: the FIFO head is consumed on a cycle with instr_valid && instr_ready;
//         instr/instr_pc are stable while instr_valid is high and not consumed.
//
// Optional build macro: IFETCH_MISALIGN_TRAP_EN adds fetch_err and a HALT
// state entered on a misaligned redirect target.
//
// dbg_state exposes the fetch FSM (0 BOOT, 1 RUN, 2 DRAIN, 3 HALT).
module ifetch_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
`ifdef IFETCH_MISALIGN_TRAP_EN
  output logic        fetch_err,
`endif
  output logic [1:0]  dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] pq_rd_q, pq_rd_d;
  logic [AW-1:0] pq_wr_q, pq_wr_d;

  logic [31:0] fifo_data_q [DEPTH];
  logic [31:0] fifo_pc_q   [DEPTH];
  logic [31:0] pcq_q       [DEPTH];

  logic          redir_en;
  logic          trap;
  logic          rsp_ok;
  logic          accept;
  logic          push;
  logic          pop;
  logic [CW:0]   credit_sum;
  logic [31:0]   redir_tgt;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic err_q, err_d;
`endif

  // Handshake decode: request credit, response acceptance and FIFO push/pop.
  always_comb begin
    redir_tgt  = redirect_pc & 32'hFFFF_FFFC;
    redir_en   = redirect && ((state_q == S_RUN) || (state_q == S_DRAIN));
`ifdef IFETCH_MISALIGN_TRAP_EN
    trap       = redir_en && (redirect_pc[1:0] != 2'b00);
`else
    trap       = 1'b0;
`endif
    // FIFO slots plus in-flight requests never exceed DEPTH, so a push
    // always has room even on a cycle where the core does not pop.
    credit_sum = {1'b0, cnt_q} + {1'b0, outst_q};
    imem_req   = (state_q == S_RUN) && !redirect && (credit_sum < CREDIT_MAX);
    imem_addr  = pc_q;
    accept     = imem_req && imem_gnt;
    // A response with nothing outstanding is a bus error and is ignored.
    rsp_ok     = imem_rvalid && (outst_q != '0);
    push       = rsp_ok && (state_q == S_RUN) && !redir_en;
    instr_valid = (cnt_q != '0) && (state_q == S_RUN) && !redir_en;
    pop        = instr_valid && instr_ready;
    instr      = fifo_data_q[rd_q];
    instr_pc   = fifo_pc_q[rd_q];
    dbg_state  = state_q;
  end

  // Next-state computation for the FSM, PC, counters and pointers.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    outst_d = outst_q + CW'(accept) - CW'(rsp_ok);
    // The per-request PC queue follows the bus, not the FIFO: stale
    // responses still retire their entry even when their data is dropped.
    pq_wr_d = pq_wr_q + AW'(accept);
    pq_rd_d = pq_rd_q + AW'(rsp_ok);
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    rd_d    = rd_q + AW'(pop);
    wr_d    = wr_q + AW'(push);
`ifdef IFETCH_MISALIGN_TRAP_EN
    err_d   = err_q | trap;
`endif

    if (redir_en) begin
      cnt_d = '0;
      rd_d  = '0;
      wr_d  = '0;
    end

    if (redir_en && !trap) begin
      pc_d = redir_tgt;
    end else if (accept) begin
      pc_d = pc_q + 32'd4;
    end

    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN, S_DRAIN: begin
        if (trap) begin
          state_d = S_HALT;
        end else if (redir_en) begin
          // Everything still in flight belongs to the old stream.
          drop_d  = outst_d;
          state_d = (outst_d != '0) ? S_DRAIN : S_RUN;
        end else if ((state_q == S_DRAIN) && rsp_ok) begin
          drop_d = drop_q - CW'(1);
          if (drop_q == CW'(1)) state_d = S_RUN;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  // Control registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      pq_rd_q <= '0;
      pq_wr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      pq_rd_q <= pq_rd_d;
      pq_wr_q <= pq_wr_d;
    end
  end

  // Storage: instruction FIFO and the address of every outstanding request.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
        pcq_q[i]       <= '0;
      end
    end else begin
      if (push) begin
        fifo_data_q[wr_q] <= imem_rdata;
        fifo_pc_q[wr_q]   <= pcq_q[pq_rd_q];
      end
      if (accept) begin
        pcq_q[pq_wr_q] <= pc_q;
      end
    end
  end

`ifdef IFETCH_MISALIGN_TRAP_EN
  // Sticky misaligned-target error flag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign fetch_err = err_q;
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed testbench for ifetch_prefetch. A behavioural instruction memory
// returns addr ^ 32'hA5A5_A5A5 after a programmable latency; the scoreboard
// holds the instr_pc values the core is expected to consume, in order.
module tb_ifetch_prefetch;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        CLK;
  logic        RST;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [1:0]  dbg_state;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        fetch_err;
  logic        o_err;
`endif

  int n_pass;
  int n_fail;
  int n_total;

  logic [31:0] exp_q[$];
  logic [31:0] pend_q[$];
  int          pend_age[$];

  int          lat;
  bit          gnt_en;
  bit          force_rv;
  logic [31:0] model_pc;
  int          grant_cnt;
  int          pop_cnt;

  logic        o_req;
  logic        o_valid;
  logic [31:0] o_addr;
  logic [31:0] o_instr;
  logic [31:0] o_pc;

  ifetch_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
`ifdef IFETCH_MISALIGN_TRAP_EN
    .fetch_err   (fetch_err),
`endif
    .dbg_state   (dbg_state)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Reset: assert asynchronously, check reset outputs, release on a negedge.
  task automatic do_reset();
    RST         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    force_rv    = 1'b0;
    gnt_en      = 1'b1;
    pend_q.delete();
    pend_age.delete();
    exp_q.delete();
    model_pc    = 32'h0;
    #1;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_req",   32'(imem_req),    32'd0);
    check("rst_instr", instr,            32'h0);
    check("rst_pc",    instr_pc,         32'h0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    check("rst_err",   32'(fetch_err),   32'd0);
`endif
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  // One bus cycle, entered and left at a negedge: drive memory, sample,
  // score any pop, then advance the memory model past the clock edge.
  task automatic cyc();
    logic        acc;
    logic        rv;
    logic [31:0] e;
    rv          = (pend_q.size() > 0) && (pend_age[0] >= lat);
    imem_rvalid = rv || force_rv;
    imem_rdata  = rv ? (pend_q[0] ^ KEY) : 32'hDEAD_BEEF;
    #1;
    imem_gnt = gnt_en && imem_req;
    #1;
    o_req   = imem_req;
    o_addr  = imem_addr;
    o_valid = instr_valid;
    o_instr = instr;
    o_pc    = instr_pc;
`ifdef IFETCH_MISALIGN_TRAP_EN
    o_err   = fetch_err;
`endif
    acc = imem_req && imem_gnt;
    if (o_req) check("imem_addr", o_addr, model_pc);
    if (redirect) begin
      check("redir_valid", 32'(o_valid), 32'd0);
      check("redir_req",   32'(o_req),   32'd0);
    end
    if (o_valid && instr_ready) begin
      pop_cnt++;
      check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("instr_pc", o_pc, e);
        check("instr", o_instr, e ^ KEY);
      end
    end
    @(posedge CLK);
    #1;
    if (rv) begin
      void'(pend_q.pop_front());
      void'(pend_age.pop_front());
    end
    foreach (pend_age[i]) pend_age[i]++;
    if (acc) begin
      pend_q.push_back(model_pc);
      pend_age.push_back(1);
      model_pc = model_pc + 32'd4;
      grant_cnt++;
    end
    if (redirect) model_pc = redirect_pc & 32'hFFFF_FFFC;
    @(negedge CLK);
  endtask

  initial begin
    int vcnt;
    int g0;
    int p0;
    n_pass = 0; n_fail = 0; n_total = 0;
    RST = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b0; lat = 1; gnt_en = 1'b1; force_rv = 1'b0;
    grant_cnt = 0; pop_cnt = 0; model_pc = 32'h0;
    #2;

    // Streaming from reset: first valid three cycles after release.
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
    pop_cnt = 0;
    cyc(); check("boot_no_req", 32'(o_req), 32'd0);
    cyc(); check("first_req",   32'(o_req), 32'd1);
    cyc(); check("no_valid_c2", 32'(o_valid), 32'd0);
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      vcnt += int'(o_valid);
    end
    check("stream_valid_cycles", 32'(vcnt), 32'd8);
    check("stream_pops", 32'(pop_cnt), 32'd8);

    // Core stalled: credit stops fetch at four, then back-to-back pops.
    do_reset();
    instr_ready = 1'b0; grant_cnt = 0; pop_cnt = 0;
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 10; i++) cyc();
    check("full_grants", 32'(grant_cnt), 32'd4);
    check("full_req_low", 32'(o_req), 32'd0);
    check("full_valid", 32'(o_valid), 32'd1);
    check("full_no_pop", 32'(pop_cnt), 32'd0);
    instr_ready = 1'b1;
    cyc(); check("pop_full_req", 32'(o_req), 32'd0);
    cyc(); check("resume_req", 32'(o_req), 32'd1);
    check("resume_addr", o_addr, 32'h0000_0010);
    for (int i = 0; i < 6; i++) cyc();
    check("drain_pops", 32'(pop_cnt), 32'd8);

    // Grant withheld: address held, then advances by one word.
    gnt_en = 1'b0; g0 = grant_cnt;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_req", 32'(o_req), 32'd1);
      check("stall_addr", o_addr, 32'h0000_002C);
    end
    check("stall_no_grant", 32'(grant_cnt), 32'(g0));
    gnt_en = 1'b1;
    cyc(); check("stall_grant_addr", o_addr, 32'h0000_002C);
    check("one_grant", 32'(grant_cnt), 32'(g0 + 1));
    cyc(); check("post_grant_addr", o_addr, 32'h0000_0030);

    // Redirect with three requests in flight at 3-cycle latency.
    do_reset();
    lat = 3; instr_ready = 1'b1; grant_cnt = 0; pop_cnt = 0;
    for (int i = 0; i < 4; i++) cyc();
    check("three_outstanding", 32'(grant_cnt), 32'd3);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h100 + 32'(i * 4));
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    cyc();
    redirect = 1'b0;
    cyc(); check("drain_req_c5", 32'(o_req), 32'd0);
    check("drain_valid_c5", 32'(o_valid), 32'd0);
    cyc(); check("drain_req_c6", 32'(o_req), 32'd0);
    cyc(); check("refetch_req", 32'(o_req), 32'd1);
    check("refetch_addr", o_addr, 32'h0000_0100);
    cyc(); cyc(); cyc();
    check("c10_no_valid", 32'(o_valid), 32'd0);
    cyc(); check("c11_valid", 32'(o_valid), 32'd1);
    check("c11_pc", o_pc, 32'h0000_0100);
    check("stale_dropped", 32'(pop_cnt), 32'd1);

    // Redirect near the top of memory: the PC wraps to zero.
    lat = 1;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(32'hFFFF_FFF8 + 32'(i * 4));
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; p0 = pop_cnt;
    cyc();
    redirect = 1'b0;
    for (int i = 0; i < 12; i++) cyc();
    check("wrap_pops", 32'((pop_cnt - p0) >= 3), 32'd1);

    // Response with nothing outstanding is ignored and leaves no debt.
    do_reset();
    lat = 1; instr_ready = 1'b1; gnt_en = 1'b0; pop_cnt = 0;
    cyc(); cyc();
    force_rv = 1'b1;
    cyc();
    force_rv = 1'b0;
    cyc(); check("spurious_no_valid", 32'(o_valid), 32'd0);
    check("spurious_req", 32'(o_req), 32'd1);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    gnt_en = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    check("spurious_recover", 32'(pop_cnt), 32'd3);

`ifdef IFETCH_MISALIGN_TRAP_EN
    // Misaligned redirect target traps until reset.
    exp_q.delete();
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    cyc();
    redirect = 1'b0;
    cyc(); check("err_set", 32'(o_err), 32'd1);
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      vcnt += int'(o_req) + int'(o_valid);
    end
    check("halt_quiet", 32'(vcnt), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    cyc();
    redirect = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      vcnt += int'(o_req) + int'(o_valid);
    end
    check("halt_ignores_redirect", 32'(vcnt), 32'd0);
    check("err_sticky", 32'(o_err), 32'd1);
    do_reset();
    cyc(); cyc();
    check("post_reset_req", 32'(o_req), 32'd1);
    check("post_reset_err", 32'(o_err), 32'd0);
`else
    // Misaligned redirect target: low bits are dropped.
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h100 + 32'(i * 4));
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    cyc();
    redirect = 1'b0;
    p0 = pop_cnt;
    for (int i = 0; i < 8; i++) cyc();
    check("misalign_cleared_pops", 32'((pop_cnt - p0) >= 2), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
